// File: rtl/urng_taus64.sv
// urng_taus64: five-component 64-bit combined Tausworthe uniform generator
// Optional sample counter output enabled by defining URNG_SAMPLE_COUNT_EN.
module urng_taus64 #(
    parameter int unsigned WARMUP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_valid,
    input  logic [63:0] seed_data,
    input  logic        pushin,
    output logic        ready,
    output logic        pushout,
    output logic [63:0] delta_denorm
`ifdef URNG_SAMPLE_COUNT_EN
    ,
    output logic [31:0] sample_cnt
`endif
);

    typedef enum logic [1:0] {
        S_SEED = 2'd0,
        S_WARM = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [63:0] DEF_SEED = 64'h0123456789ABCDEF;
    localparam logic [7:0]  WLAST    = 8'(WARMUP - 1);

    state_t      state_q, state_d;
    logic [63:0] z1_q, z2_q, z3_q, z4_q, z5_q;
    logic [63:0] z1_n, z2_n, z3_n, z4_n, z5_n;
    logic [63:0] sample;
    logic [2:0]  widx_q;
    logic [2:0]  seed_idx;
    logic [7:0]  warm_q;
    logic        pushout_q;
    logic [63:0] delta_q;
    logic        step;
    logic        sample_en;
    logic        seed_entry;

    // One generator step for each component (logical shifts)
    always_comb begin
        z1_n = ((z1_q & ~64'd1) << 10)
             ^ (((z1_q << 1) ^ z1_q) >> 53);
        z2_n = ((z2_q & ~64'd511) << 5)
             ^ (((z2_q << 24) ^ z2_q) >> 50);
        z3_n = ((z3_q & ~64'd4095) << 29)
             ^ (((z3_q << 3) ^ z3_q) >> 23);
        z4_n = ((z4_q & ~64'd131071) << 23)
             ^ (((z4_q << 5) ^ z4_q) >> 24);
        z5_n = ((z5_q & ~64'd8388607) << 8)
             ^ (((z5_q << 3) ^ z5_q) >> 33);
        sample = z1_n ^ z2_n ^ z3_n ^ z4_n ^ z5_n;
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_WARM;
        else     state_q <= state_d;
    end

    // FSM next state: a seed word always wins over warm-up and sampling
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_SEED: if (seed_valid && widx_q == 3'd4) state_d = S_WARM;
            S_WARM: begin
                if (seed_valid)           state_d = S_SEED;
                else if (warm_q == WLAST) state_d = S_RUN;
            end
            S_RUN:  if (seed_valid) state_d = S_SEED;
            default: state_d = S_WARM;
        endcase
    end

    // FSM outputs and datapath controls
    always_comb begin
        ready      = (state_q == S_RUN);
        sample_en  = (state_q == S_RUN) && pushin && !seed_valid;
        step       = sample_en || ((state_q == S_WARM) && !seed_valid);
        seed_entry = seed_valid && (state_q != S_SEED);
        seed_idx   = (state_q == S_SEED) ? widx_q : 3'd0;
    end

    // Generator state: seed load (forced above component minimum) or step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z1_q <= DEF_SEED;
            z2_q <= DEF_SEED;
            z3_q <= DEF_SEED;
            z4_q <= DEF_SEED;
            z5_q <= DEF_SEED;
        end else if (seed_valid) begin
            unique case (seed_idx)
                3'd0: z1_q <= seed_data | 64'd2;
                3'd1: z2_q <= seed_data | 64'd512;
                3'd2: z3_q <= seed_data | 64'd4096;
                3'd3: z4_q <= seed_data | 64'd131072;
                3'd4: z5_q <= seed_data | 64'd8388608;
                default: ;
            endcase
        end else if (step) begin
            z1_q <= z1_n;
            z2_q <= z2_n;
            z3_q <= z3_n;
            z4_q <= z4_n;
            z5_q <= z5_n;
        end
    end

    // Seed word index and warm-up step counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            widx_q <= 3'd0;
            warm_q <= 8'd0;
        end else begin
            if (seed_valid)
                widx_q <= (seed_idx == 3'd4) ? 3'd0 : seed_idx + 3'd1;
            if (seed_valid)
                warm_q <= 8'd0;
            else if (state_q == S_WARM)
                warm_q <= warm_q + 8'd1;
        end
    end

    // Output sample register, one cycle after pushin
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pushout_q <= 1'b0;
            delta_q   <= 64'd0;
        end else begin
            pushout_q <= sample_en;
            if (sample_en) delta_q <= sample;
        end
    end

    assign pushout      = pushout_q;
    assign delta_denorm = delta_q;

`ifdef URNG_SAMPLE_COUNT_EN
    logic [31:0] cnt_q;

    // Count delivered samples since last reseed
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             cnt_q <= 32'd0;
        else if (seed_entry) cnt_q <= 32'd0;
        else if (sample_en)  cnt_q <= cnt_q + 32'd1;
    end

    assign sample_cnt = cnt_q;
`else
    logic unused_entry;
    assign unused_entry = seed_entry;
`endif

endmodule

// File: tb/tb_urng_taus64.sv
// tb_urng_taus64: scoreboard bench for urng_taus64
// Reference lfsr258 model plus FSM model predict every output cycle.
module tb_urng_taus64;

    localparam int WARMUP = 16;
    localparam logic [63:0] DEF_SEED = 64'h0123456789ABCDEF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_valid = 1'b0;
    logic [63:0] seed_data = 64'd0;
    logic        pushin = 1'b0;
    logic        ready;
    logic        pushout;
    logic [63:0] delta_denorm;
`ifdef URNG_SAMPLE_COUNT_EN
    logic [31:0] sample_cnt;
`endif

    urng_taus64 #(.WARMUP(WARMUP)) dut (
        .clk          (clk),
        .rst          (rst),
        .seed_valid   (seed_valid),
        .seed_data    (seed_data),
        .pushin       (pushin),
        .ready        (ready),
        .pushout      (pushout),
        .delta_denorm (delta_denorm)
`ifdef URNG_SAMPLE_COUNT_EN
        ,
        .sample_cnt   (sample_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [63:0] mz [5];
    int          mst;
    int          midx;
    int          mwarm;
    logic        exp_po;
    logic [63:0] last_d;
    logic [31:0] mcnt;
    logic [63:0] sbq [$];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] cmask(input int k);
        case (k)
            0: return 64'd1;
            1: return 64'd511;
            2: return 64'd4095;
            3: return 64'd131071;
            default: return 64'd8388607;
        endcase
    endfunction

    function automatic logic [63:0] tstep(input int k, input logic [63:0] z);
        int a, b, c;
        case (k)
            0: begin a = 1;  b = 53; c = 10; end
            1: begin a = 24; b = 50; c = 5;  end
            2: begin a = 3;  b = 23; c = 29; end
            3: begin a = 5;  b = 24; c = 23; end
            default: begin a = 3; b = 33; c = 8; end
        endcase
        return ((z & ~cmask(k)) << c) ^ (((z << a) ^ z) >> b);
    endfunction

    task automatic gen(output logic [63:0] s);
        s = 64'd0;
        for (int k = 0; k < 5; k++) begin
            mz[k] = tstep(k, mz[k]);
            s ^= mz[k];
        end
    endtask

    task automatic tick();
        logic [63:0] s;
        exp_po = 1'b0;
        if (seed_valid) begin
            if (mst != 0) begin
                midx = 0;
                mcnt = 32'd0;
            end
            mz[midx] = seed_data | (cmask(midx) + 64'd1);
            if (midx == 4) begin
                mst = 1;
                mwarm = 0;
                midx = 0;
            end else begin
                mst = 0;
                midx++;
            end
        end else if (mst == 1) begin
            gen(s);
            mwarm++;
            if (mwarm == WARMUP) mst = 2;
        end else if (mst == 2 && pushin) begin
            gen(s);
            sbq.push_back(s);
            exp_po = 1'b1;
            mcnt++;
        end
        @(posedge clk);
        #1;
        chk("ready", ready, 64'(mst == 2));
        chk("pushout", pushout, 64'(exp_po));
        if (pushout) begin
            chk("sbq_nonempty", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) last_d = sbq.pop_front();
            chk("sample", delta_denorm, last_d);
        end else begin
            chk("hold", delta_denorm, last_d);
        end
`ifdef URNG_SAMPLE_COUNT_EN
        chk("cnt", 64'(sample_cnt), 64'(mcnt));
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        seed_valid = 1'b0;
        pushin = 1'b0;
        #1;
        chk("rst_po", 64'(pushout), 64'd0);
        chk("rst_rdy", 64'(ready), 64'd0);
        chk("rst_dd", delta_denorm, 64'd0);
`ifdef URNG_SAMPLE_COUNT_EN
        chk("rst_cnt", 64'(sample_cnt), 64'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) mz[k] = DEF_SEED;
        mst = 1;
        mwarm = 0;
        midx = 0;
        sbq.delete();
        last_d = 64'd0;
        mcnt = 32'd0;
    endtask

    task automatic seed_word(input logic [63:0] w);
        seed_valid = 1'b1;
        seed_data = w;
        tick();
        seed_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'(WARMUP));
    endtask

    initial begin
        mst = 1;
        midx = 0;
        mwarm = 0;
        mcnt = 32'd0;
        last_d = 64'd0;
        exp_po = 1'b0;
        for (int k = 0; k < 5; k++) mz[k] = DEF_SEED;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        wait_ready("warm_len_rst");

        pushin = 1'b1; tick();
        pushin = 1'b0; tick();
        tick();
        pushin = 1'b1; tick();
        pushin = 1'b0; tick();
        tick();

        seed_valid = 1'b1;
        pushin = 1'b1;
        seed_data = 64'd0;
        tick();
        pushin = 1'b0;
        seed_valid = 1'b0;
        for (int i = 0; i < 4; i++) seed_word(64'd0);
        chk("z1", dut.z1_q, 64'd2);
        chk("z2", dut.z2_q, 64'd512);
        chk("z3", dut.z3_q, 64'd4096);
        chk("z4", dut.z4_q, 64'd131072);
        chk("z5", dut.z5_q, 64'd8388608);
        wait_ready("warm_len_zero");
        pushin = 1'b1;
        repeat (1000) tick();
        pushin = 1'b0;
        tick();

        pushin = 1'b1;
        for (int i = 0; i < 5; i++) seed_word({$urandom, $urandom});
        wait_ready("warm_len_rand");
        for (int i = 0; i < 300; i++) begin
            pushin = 1'($urandom_range(0, 1));
            tick();
        end
        pushin = 1'b0;

        for (int i = 0; i < 5; i++) seed_word({$urandom, $urandom});
        repeat (3) tick();
        for (int i = 0; i < 5; i++) seed_word({$urandom, $urandom});
        wait_ready("warm_len_abort");
        pushin = 1'b1;
        repeat (20) tick();
        pushin = 1'b0;

        seed_word({$urandom, $urandom});
        seed_word({$urandom, $urandom});
        do_reset();
        pushin = 1'b1;
        wait_ready("warm_len_rst2");
        repeat (5) tick();
        pushin = 1'b0;
        tick();

`ifdef URNG_SAMPLE_COUNT_EN
        for (int i = 0; i < 5; i++) seed_word(64'd0);
        wait_ready("warm_len_cnt");
        pushin = 1'b1;
        repeat (5) tick();
        pushin = 1'b0;
        tick();
        chk("cnt5", 64'(sample_cnt), 64'd5);
        seed_word(64'd0);
        chk("cnt_clr", 64'(sample_cnt), 64'd0);
        for (int i = 0; i < 4; i++) seed_word(64'd0);
        wait_ready("warm_len_cnt2");
        force dut.cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.cnt_q;
        mcnt = 32'hFFFFFFFF;
        pushin = 1'b1;
        tick();
        pushin = 1'b0;
        chk("cnt_wrap", 64'(sample_cnt), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
